image_wr_counter: RTL and testbench
===================================

Name: image_wr_counter

Overview:
- Column counter for the image-write path out of SRAM.
- Counts enabled pixel/column strobes from 0 up to (rollover_val − 1), then wraps to 0 and flags the wrap (end of image row).
- Sits between the SRAM read sequencer and the image writer. It gives the current column index and a row-complete indication.

Parameters:
- WIDTH, 13, bit width of value and rollover_val (supports image widths up to 8191).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- clear  input  1  synchronous active-high reset/clear; sampled on rising edge of clk.
- rollover_val  input  WIDTH  image width; the number of counts per row (count sequence is 0..rollover_val−1).
- count_enable  input  1  increment request; one count per rising edge while high.
- rollover_flag  output  1  registered; high after the counter wraps to 0, until the next count or clear.
- value  output  WIDTH  registered current column count.

Behaviour:
- All state (value, rollover_flag) is registered on the rising edge of clk. Outputs come directly from flops, with no combinational path from inputs.
- Reset/clear: when clear=1 at a rising edge, value←0 and rollover_flag←0, regardless of count_enable. clear has highest priority. There is no power-on reset beyond clear; the bench must assert clear before use.
- Hold: clear=0 and count_enable=0 → value and rollover_flag hold.
- Count, clear=0 and count_enable=1:
  - If value ≥ rollover_val − 1 (wrap condition): value←0, rollover_flag←1.
  - Otherwise: value←value+1, rollover_flag←0.
- Latency: value and flag reflect an enabled edge immediately after that edge (one-cycle registered).
- rollover_flag stays high while value sits at 0 after a wrap. It drops on the next enabled count (value→1) or on clear.
- Continuous enable: count_enable held high for N edges gives N counts, wrapping as needed. A wrap-then-increment in consecutive cycles is legal.
- Arithmetic:
  - Compare against rollover_val − 1 computed at WIDTH+1 bits, so no negative wrap.
  - rollover_val = 0 or 1: every enabled edge yields value=0, rollover_flag=1.
  - rollover_val = all-ones (8191): sequence 0..8190, then wrap.
  - value never reaches or exceeds rollover_val through counting.
- rollover_val changed mid-row: takes effect immediately. If the current value already satisfies the wrap condition, the next enabled edge wraps to 0 with flag=1.
- rollover_val may change freely while count_enable=0, without effect on state.
- Implementation includes the registered counter, wrap comparator, flag register, and an optional assertion block checking value < rollover_val when rollover_val > 0.

Test Plan:
- Clear: rollover_val=10, pulse clear one cycle → value=0, rollover_flag=0; hold with count_enable=0 for 3 cycles → unchanged.
- Width 10, single-cycle enable pulses separated by 3 idle cycles: after pulses 1..9 → value=1..9, flag=0. Pulse 10 → value=0, flag=1. Pulse 11 → value=1, flag=0.
- Width 100, same pulse pattern: value tracks 1..99 with flag=0; pulse 100 → value=0, flag=1; pulse 101 → value=1, flag=0.
- Width 8191 (all ones): 8190 pulses → value=8190, flag=0; next → value=0, flag=1; next → value=1, flag=0.
- Priority and continuous enable: rollover_val=4, hold count_enable high → sequence 1,2,3,0(flag=1),1(flag=0). Assert clear together with count_enable → value=0, flag=0.
- Degenerate and mid-row change: rollover_val=1 with enable → value stays 0, flag=1 each edge. At value=7 with width 10, change rollover_val to 5 and enable → value=0, flag=1.

Source files
------------

// File: rtl/image_wr_counter.sv
// Column counter for the SRAM-to-image write path: counts enabled strobes
// from 0 to rollover_val-1, then wraps to 0 and raises rollover_flag.
module image_wr_counter #(
    parameter int WIDTH = 13
) (
    input  logic             clk,
    input  logic             clear,
    input  logic [WIDTH-1:0] rollover_val,
    input  logic             count_enable,
    output logic             rollover_flag,
    output logic [WIDTH-1:0] value
);

    logic [WIDTH-1:0] value_q;
    logic [WIDTH-1:0] value_d;
    logic             flag_q;
    logic             flag_d;
    logic [WIDTH:0]   valuePlusOne;
    logic             wrapHit;

    // Testing value+1 >= rollover_val in WIDTH+1 bits is the same as
    // value >= rollover_val-1, and it still wraps for rollover_val of 0 or 1.
    assign valuePlusOne = {1'b0, value_q} + {{WIDTH{1'b0}}, 1'b1};
    assign wrapHit      = (valuePlusOne >= {1'b0, rollover_val});

    always_comb begin
        value_d = value_q;
        flag_d  = flag_q;
        if (clear) begin
            value_d = '0;
            flag_d  = 1'b0;
        end else if (count_enable) begin
            if (wrapHit) begin
                value_d = '0;
                flag_d  = 1'b1;
            end else begin
                value_d = valuePlusOne[WIDTH-1:0];
                flag_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        value_q <= value_d;
        flag_q  <= flag_d;
    end

    assign value         = value_q;
    assign rollover_flag = flag_q;

`ifndef SYNTHESIS
    // A count never lands at or above the width that was in force on its edge.
    property pValueInRange;
        @(posedge clk) disable iff (clear)
            (count_enable && (rollover_val != '0)) |=> (value < $past(rollover_val));
    endproperty
    assert property (pValueInRange);
`endif

endmodule

// File: tb/tb_image_wr_counter.sv
// Scoreboard bench for image_wr_counter: stimulus queues the expected
// value/flag for each edge, a monitor pops and compares after that edge.
module tb_image_wr_counter;

    localparam int WIDTH = 13;

    logic             clk = 1'b0;
    logic             clear = 1'b1;
    logic             count_enable = 1'b0;
    logic [WIDTH-1:0] rollover_val = 13'd10;
    logic             rollover_flag;
    logic [WIDTH-1:0] value;

    typedef struct {
        logic [WIDTH-1:0] v;
        logic             f;
        int               step;
    } expT;

    expT expQ[$];
    int  compared   = 0;
    int  mismatched = 0;
    int  stepNo     = 0;

    always #5 clk = ~clk;

    image_wr_counter #(.WIDTH(WIDTH)) dut (
        .clk          (clk),
        .clear        (clear),
        .rollover_val (rollover_val),
        .count_enable (count_enable),
        .rollover_flag(rollover_flag),
        .value        (value)
    );

    // Monitor: one queued expectation is due just after each edge.
    initial begin
        expT e;
        forever begin
            @(posedge clk);
            #1;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                compared++;
                if (value !== e.v || rollover_flag !== e.f) begin
                    mismatched++;
                    $display("[TB] FAIL step%0d: value=%0d flag=%0b, required value=%0d flag=%0b",
                             e.step, value, rollover_flag, e.v, e.f);
                end
            end
        end
    end

    task automatic applyStimulus(input logic clr, input logic en, input logic [WIDTH-1:0] rv,
                                 input logic [WIDTH-1:0] ev, input logic ef);
        expT e;
        @(posedge clk);
        #2;
        clear        = clr;
        count_enable = en;
        rollover_val = rv;
        stepNo++;
        e.v = ev;
        e.f = ef;
        e.step = stepNo;
        expQ.push_back(e);
    endtask

    // Clear, then W+1 single pulses each followed by idle cycles.
    // Pulse k leaves value = k mod W, flag set only on pulse W.
    task automatic pulseRun(input int w, input int idle);
        logic [WIDTH-1:0] ev;
        logic             ef;
        applyStimulus(1'b1, 1'b0, WIDTH'(w), '0, 1'b0);
        for (int k = 1; k <= w + 1; k++) begin
            ev = WIDTH'(k % w);
            ef = (k == w);
            applyStimulus(1'b0, 1'b1, WIDTH'(w), ev, ef);
            for (int j = 0; j < idle; j++)
                applyStimulus(1'b0, 1'b0, WIDTH'(w), ev, ef);
        end
    endtask

    initial begin
        // Clear and hold
        applyStimulus(1'b1, 1'b0, 13'd10, 13'd0, 1'b0);
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b0, 1'b0, 13'd10, 13'd0, 1'b0);

        pulseRun(10, 3);
        pulseRun(100, 3);
        pulseRun(8191, 1);

        // Continuous enable with width 4, then clear beating enable
        applyStimulus(1'b1, 1'b0, 13'd4, 13'd0, 1'b0);
        applyStimulus(1'b0, 1'b1, 13'd4, 13'd1, 1'b0);
        applyStimulus(1'b0, 1'b1, 13'd4, 13'd2, 1'b0);
        applyStimulus(1'b0, 1'b1, 13'd4, 13'd3, 1'b0);
        applyStimulus(1'b0, 1'b1, 13'd4, 13'd0, 1'b1);
        applyStimulus(1'b0, 1'b1, 13'd4, 13'd1, 1'b0);
        applyStimulus(1'b1, 1'b1, 13'd4, 13'd0, 1'b0);

        // Degenerate widths 1 and 0
        applyStimulus(1'b0, 1'b1, 13'd1, 13'd0, 1'b1);
        applyStimulus(1'b0, 1'b1, 13'd1, 13'd0, 1'b1);
        applyStimulus(1'b0, 1'b1, 13'd1, 13'd0, 1'b1);
        applyStimulus(1'b0, 1'b0, 13'd1, 13'd0, 1'b1);
        applyStimulus(1'b0, 1'b1, 13'd0, 13'd0, 1'b1);
        applyStimulus(1'b0, 1'b1, 13'd0, 13'd0, 1'b1);

        // Mid-row shrink: reach 7 at width 10, then width 5 forces a wrap
        applyStimulus(1'b1, 1'b0, 13'd10, 13'd0, 1'b0);
        for (int k = 1; k <= 7; k++)
            applyStimulus(1'b0, 1'b1, 13'd10, WIDTH'(k), 1'b0);
        applyStimulus(1'b0, 1'b1, 13'd5, 13'd0, 1'b1);
        applyStimulus(1'b0, 1'b1, 13'd5, 13'd1, 1'b0);

        // Width changes while idle leave state alone; next count uses new width
        applyStimulus(1'b0, 1'b0, 13'd3, 13'd1, 1'b0);
        applyStimulus(1'b0, 1'b0, 13'd9, 13'd1, 1'b0);
        applyStimulus(1'b0, 1'b1, 13'd2, 13'd0, 1'b1);
        applyStimulus(1'b0, 1'b0, 13'd2, 13'd0, 1'b1);

        // Bounded drain of the scoreboard
        @(posedge clk);
        #3;
        count_enable = 1'b0;
        if (expQ.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL drain: pending=%0d, required pending=0", expQ.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
